scroll_controller: RTL and testbench
====================================

SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 Parameter MAX_OFFSET, default 2096, is the largest legal scroll offset in pixels (211 tiles x 16 px - 1280 visible px).
REQ-002 Parameter RIGHT_THRESH, default 11'd800, is the centroid x above which the view scrolls forward.
REQ-003 Parameter LEFT_THRESH, default 11'd400, is the centroid x below which the view scrolls backward.
REQ-004 Parameter MAX_SPEED, default 4, is the largest per-frame scroll step in pixels.
REQ-005 Parameter RAMP_FRAMES, default 8, is the number of consecutive same-direction frames needed per speed increment.
REQ-006 Parameter STUN_FRAMES, default 30, is the freeze length in frames after a collision.
REQ-007 Parameter KNOCKBACK, default 64, is the backward offset jump in pixels applied on a collision.
REQ-008 pixel_clk_in  input  1  pixel clock; the block's only clock.
REQ-009 rst_in  input  1  reset; synchronous and active-high.
REQ-010 new_frame  input  1  one-cycle pulse marking a frame boundary.
REQ-011 enable  input  1  game running; low holds the controller idle.
REQ-012 x_center_mass  input  11  hand centroid x in screen pixels.
REQ-013 collision_output  input  1  per-pixel collision flag from the tile lookup stage.
REQ-014 offset  output  12  registered horizontal scroll offset feeding the tile lookup stage.
REQ-015 speed  output  3  current step magnitude in pixels, 1..MAX_SPEED.
REQ-016 stunned  output  1  high while in the STUN state.
REQ-017 level_done  output  1  high while in the DONE state.

Function
REQ-018 offset, speed, stunned and level_done SHALL change only on the cycle after new_frame is high, so offset stays constant for the whole frame.
REQ-019 A sticky collision latch SHALL set on any cycle with collision_output high and clear on new_frame; a collision on the same cycle as new_frame SHALL count toward the ending frame.
REQ-020 x_center_mass SHALL be sampled only on new_frame.
REQ-021 The controller SHALL have four states: IDLE, SCROLL, STUN and DONE.
REQ-022 IDLE->SCROLL SHALL occur on new_frame with enable high; any state->IDLE SHALL occur on new_frame with enable low; offset SHALL be held in IDLE.
REQ-023 In SCROLL, on new_frame with the collision latch set: offset = max(offset - KNOCKBACK, 0), speed = 1, stun counter = STUN_FRAMES - 1, next state = STUN.
REQ-024 In SCROLL with no collision: x > RIGHT_THRESH gives offset = min(offset + speed, MAX_OFFSET); x < LEFT_THRESH gives offset = max(offset - speed, 0); otherwise offset is held.
REQ-025 Offset arithmetic SHALL use 13 bits with saturation, so it never wraps.
REQ-026 Speed ramp: a counter of consecutive frames in the same direction; each RAMP_FRAMES such frames increments speed, saturating at MAX_SPEED.
REQ-027 A direction change or a dead-zone frame SHALL reset speed to 1 and the ramp counter to 0.
REQ-028 STUN SHALL ignore centroid and collisions, decrement the stun counter each new_frame, and return to SCROLL on the new_frame where the counter is 0.
REQ-029 SCROLL->DONE SHALL occur when an update makes offset equal to MAX_OFFSET.
REQ-030 DONE SHALL hold offset and leave only via reset or enable low.
REQ-031 A collision in the same frame that reaches MAX_OFFSET SHALL take priority: the next state is STUN, not DONE.

Reset
REQ-032 While rst_in is high at a clock edge: state = IDLE, offset = 0, speed = 1, stunned = 0, level_done = 0, and all counters and the collision latch are cleared.
REQ-033 Reset SHALL take priority over new_frame on the same cycle, and reset mid-stun SHALL abandon the stun.

Structure
REQ-034 Package scroll_pkg SHALL hold the state enum and the default constants (MAX_OFFSET, the thresholds, MAX_SPEED, RAMP_FRAMES, STUN_FRAMES, KNOCKBACK).
REQ-035 Sub-module scroll_speed_ramp SHALL contain the direction and ramp counter and the speed register.

Verification
REQ-036 Reset, enable=1, x=1000 for 20 frames -> offset increases by 1 per frame for 8 frames, then by 2 per frame; speed reaches 3 at frame 17.
REQ-037 offset=100, a collision pulse mid-frame -> next frame offset=36, stunned=1 for 30 frames, offset frozen, then SCROLL resumes.
REQ-038 offset=20, collision -> offset=0 (no wrap); x=100 at offset 0 -> offset stays 0.
REQ-039 offset=2094 with speed 4, x=1000 -> offset=2096 and level_done=1; further frames hold the offset.
REQ-040 Collision asserted on the same cycle as new_frame -> treated as the ending frame's collision; rst_in asserted during STUN -> next cycle offset=0 and state IDLE.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared types, default tuning constants and saturating offset helpers
// for the side-scrolling view controller.
package scroll_pkg;

  typedef enum logic [1:0] {IDLE, SCROLL, STUN, DONE} scroll_state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_BACK} scroll_dir_t;

  localparam int          DEF_MAX_OFFSET   = 2096;
  localparam logic [10:0] DEF_RIGHT_THRESH = 11'd800;
  localparam logic [10:0] DEF_LEFT_THRESH  = 11'd400;
  localparam int          DEF_MAX_SPEED    = 4;
  localparam int          DEF_RAMP_FRAMES  = 8;
  localparam int          DEF_STUN_FRAMES  = 30;
  localparam int          DEF_KNOCKBACK    = 64;

  // 13-bit intermediate so the sum can exceed the limit without wrapping.
  function automatic logic [11:0] sat_add(input logic [11:0] a,
                                          input logic [12:0] b,
                                          input logic [11:0] limit);
    logic [12:0] sum;
    sum = {1'b0, a} + b;
    return (sum > {1'b0, limit}) ? limit : sum[11:0];
  endfunction

  function automatic logic [11:0] sat_sub(input logic [11:0] a,
                                          input logic [12:0] b);
    return (b > {1'b0, a}) ? 12'd0 : (a - b[11:0]);
  endfunction

endpackage

// File: rtl/scroll_speed_ramp.sv
// Tracks the run of consecutive same-direction frames and ramps the
// scroll step from 1 up to MAX_SPEED.
module scroll_speed_ramp
  import scroll_pkg::*;
#(
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int RAMP_FRAMES = DEF_RAMP_FRAMES
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        update,
  input  logic        clear,
  input  scroll_dir_t dir,
  output logic [2:0]  speed,
  output logic [2:0]  step
);

  localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  scroll_dir_t       last_dir;
  logic [RAMP_W-1:0] ramp_cnt;

  // A reversal moves by a single pixel rather than at the old run's speed.
  assign step = (dir == last_dir) ? speed : 3'd1;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in || clear) begin
      speed    <= 3'd1;
      ramp_cnt <= '0;
      last_dir <= DIR_NONE;
    end else if (update) begin
      if (dir == DIR_NONE) begin
        speed    <= 3'd1;
        ramp_cnt <= '0;
        last_dir <= DIR_NONE;
      end else if (dir != last_dir) begin
        speed    <= 3'd1;
        ramp_cnt <= RAMP_W'(1);
        last_dir <= dir;
      end else if (ramp_cnt == RAMP_W'(RAMP_FRAMES - 1)) begin
        ramp_cnt <= '0;
        if (speed < 3'(MAX_SPEED))
          speed <= speed + 3'd1;
      end else begin
        ramp_cnt <= ramp_cnt + RAMP_W'(1);
      end
    end
  end

endmodule

// File: rtl/scroll_controller.sv
// Frame-synchronous scroll controller: steers the view offset from the hand
// centroid, with knockback/stun on collisions and a level-complete state.
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int          MAX_OFFSET   = DEF_MAX_OFFSET,
  parameter logic [10:0] RIGHT_THRESH = DEF_RIGHT_THRESH,
  parameter logic [10:0] LEFT_THRESH  = DEF_LEFT_THRESH,
  parameter int          MAX_SPEED    = DEF_MAX_SPEED,
  parameter int          RAMP_FRAMES  = DEF_RAMP_FRAMES,
  parameter int          STUN_FRAMES  = DEF_STUN_FRAMES,
  parameter int          KNOCKBACK    = DEF_KNOCKBACK
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        new_frame,
  input  logic        enable,
  input  logic [10:0] x_center_mass,
  input  logic        collision_output,
  output logic [11:0] offset,
  output logic [2:0]  speed,
  output logic        stunned,
  output logic        level_done
);

  localparam int          STUN_W  = (STUN_FRAMES > 1) ? $clog2(STUN_FRAMES) : 1;
  localparam logic [11:0] MAX_OFF = 12'(MAX_OFFSET);
  localparam logic [12:0] KNOCK   = 13'(KNOCKBACK);

  scroll_state_t     state, state_n;
  scroll_dir_t       dir;
  logic [11:0]       offset_n;
  logic [STUN_W-1:0] stun_cnt, stun_n;
  logic              coll_latch, coll_seen;
  logic              ramp_update, ramp_clear;
  logic [2:0]        step;

  // A hit on the frame-boundary cycle still belongs to the frame that is ending.
  assign coll_seen  = coll_latch | collision_output;
  assign stunned    = (state == STUN);
  assign level_done = (state == DONE);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      offset     <= '0;
      stun_cnt   <= '0;
      coll_latch <= 1'b0;
    end else begin
      state      <= state_n;
      offset     <= offset_n;
      stun_cnt   <= stun_n;
      coll_latch <= new_frame ? 1'b0 : coll_seen;
    end
  end

  always_comb begin
    dir = DIR_NONE;
    if (x_center_mass > RIGHT_THRESH)
      dir = DIR_FWD;
    else if (x_center_mass < LEFT_THRESH)
      dir = DIR_BACK;
  end

  always_comb begin
    state_n     = state;
    offset_n    = offset;
    stun_n      = stun_cnt;
    ramp_update = 1'b0;
    ramp_clear  = 1'b0;
    if (new_frame) begin
      if (!enable) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE: state_n = SCROLL;
          SCROLL: begin
            if (coll_seen) begin
              offset_n   = sat_sub(offset, KNOCK);
              stun_n     = STUN_W'(STUN_FRAMES - 1);
              ramp_clear = 1'b1;
              state_n    = STUN;
            end else begin
              ramp_update = 1'b1;
              if (dir == DIR_FWD) begin
                offset_n = sat_add(offset, {10'd0, step}, MAX_OFF);
                if (offset_n == MAX_OFF)
                  state_n = DONE;
              end else if (dir == DIR_BACK) begin
                offset_n = sat_sub(offset, {10'd0, step});
              end
            end
          end
          STUN: begin
            if (stun_cnt == '0)
              state_n = SCROLL;
            else
              stun_n = stun_cnt - STUN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  scroll_speed_ramp #(
    .MAX_SPEED  (MAX_SPEED),
    .RAMP_FRAMES(RAMP_FRAMES)
  ) u_ramp (
    .pixel_clk_in(pixel_clk_in),
    .rst_in      (rst_in),
    .update      (ramp_update),
    .clear       (ramp_clear),
    .dir         (dir),
    .speed       (speed),
    .step        (step)
  );

endmodule

// File: tb/tb_scroll_controller.sv
// Scoreboard bench for scroll_controller: a frame-level reference model pushes
// expected outputs per frame; a monitor checks them after each frame update.
module tb_scroll_controller;

  localparam int MAX_OFF  = 2096;
  localparam int RT       = 800;
  localparam int LT       = 400;
  localparam int MAXSPD   = 4;
  localparam int RAMP     = 8;
  localparam int STUNF    = 30;
  localparam int KNOCK    = 64;

  localparam int M_IDLE   = 0;
  localparam int M_SCROLL = 1;
  localparam int M_STUN   = 2;
  localparam int M_DONE   = 3;

  typedef struct {
    int offset;
    int speed;
    int stunned;
    int done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        new_frame = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] x_center_mass = '0;
  logic        collision_output = 1'b0;
  logic [11:0] offset;
  logic [2:0]  speed;
  logic        stunned;
  logic        level_done;
  logic        nf_q = 1'b0;

  int   nChecks = 0;
  int   nFail   = 0;
  exp_t expQ[$];

  // reference model state
  int m_mode, m_offset, m_run, m_dir, m_stunLeft;
  bit m_coll;

  scroll_controller dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_in),
    .new_frame       (new_frame),
    .enable          (enable),
    .x_center_mass   (x_center_mass),
    .collision_output(collision_output),
    .offset          (offset),
    .speed           (speed),
    .stunned         (stunned),
    .level_done      (level_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) nf_q <= new_frame;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int mSpeed();
    int s;
    s = 1 + m_run / RAMP;
    return (s > MAXSPD) ? MAXSPD : s;
  endfunction

  function automatic exp_t mExp();
    exp_t e;
    e.offset  = m_offset;
    e.speed   = mSpeed();
    e.stunned = (m_mode == M_STUN) ? 1 : 0;
    e.done    = (m_mode == M_DONE) ? 1 : 0;
    return e;
  endfunction

  task automatic modelReset;
    m_mode = M_IDLE; m_offset = 0; m_run = 0; m_dir = 0; m_stunLeft = 0; m_coll = 0;
  endtask

  task automatic modelFrame(input int x, input bit en, input bit coll);
    int d, st;
    if (!en) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SCROLL;
    end else if (m_mode == M_SCROLL) begin
      if (coll) begin
        m_offset   = (m_offset > KNOCK) ? m_offset - KNOCK : 0;
        m_run      = 0;
        m_dir      = 0;
        m_stunLeft = STUNF;
        m_mode     = M_STUN;
      end else begin
        d = (x > RT) ? 1 : ((x < LT) ? -1 : 0);
        if (d == 0) begin
          m_run = 0;
          m_dir = 0;
        end else begin
          if (d != m_dir) m_run = 0;
          st = mSpeed();
          m_offset = m_offset + d * st;
          if (m_offset < 0) m_offset = 0;
          if (m_offset > MAX_OFF) m_offset = MAX_OFF;
          m_dir = d;
          m_run++;
          if (d == 1 && m_offset == MAX_OFF) m_mode = M_DONE;
        end
      end
    end else if (m_mode == M_STUN) begin
      m_stunLeft--;
      if (m_stunLeft == 0) m_mode = M_SCROLL;
    end
  endtask

  // One frame: boundary cycle followed by len-1 mid-frame cycles with junk x.
  task automatic applyStimulus(input int x, input bit en, input bit collMid,
                               input bit collAtNf, input int len);
    new_frame        = 1'b1;
    enable           = en;
    x_center_mass    = 11'(x);
    collision_output = collAtNf;
    modelFrame(x, en, m_coll | collAtNf);
    m_coll = 0;
    expQ.push_back(mExp());
    tick;
    new_frame        = 1'b0;
    collision_output = 1'b0;
    for (int i = 1; i < len; i++) begin
      x_center_mass    = 11'($urandom_range(0, 2047));
      collision_output = collMid && (i == 1);
      if (collision_output) m_coll = 1;
      tick;
    end
    collision_output = 1'b0;
  endtask

  task automatic resetDut;
    rst_in           = 1'b1;
    new_frame        = 1'b1;
    collision_output = 1'b1;
    modelReset();
    expQ.push_back(mExp());
    tick;
    rst_in           = 1'b0;
    new_frame        = 1'b0;
    collision_output = 1'b0;
    tick;
  endtask

  // Monitor: compare after every frame update, and check outputs hold in between.
  initial begin
    exp_t cur;
    bit   have;
    have = 0;
    forever begin
      @(negedge clk);
      if (nf_q) begin
        if (expQ.size() == 0) begin
          checkOutput("queue_underflow", 1, 0);
        end else begin
          cur  = expQ.pop_front();
          have = 1;
          checkOutput("offset", int'(offset), cur.offset);
          checkOutput("speed", int'(speed), cur.speed);
          checkOutput("stunned", int'(stunned), cur.stunned);
          checkOutput("level_done", int'(level_done), cur.done);
        end
      end else if (have) begin
        checkOutput("offset_hold", int'(offset), cur.offset);
        checkOutput("speed_hold", int'(speed), cur.speed);
        checkOutput("stunned_hold", int'(stunned), cur.stunned);
        checkOutput("level_done_hold", int'(level_done), cur.done);
      end
    end
  end

  initial begin
    int  x, st, r, guard;
    bit  c;
    modelReset();
    tick;
    resetDut();

    $display("[TB] ramp from reset");
    repeat (21) applyStimulus(1000, 1, 0, 0, 4);

    $display("[TB] knockback and stun");
    applyStimulus(600, 1, 1, 0, 4);
    repeat (32) applyStimulus(1000, 1, 0, 0, 4);

    $display("[TB] lower bound");
    repeat (40) applyStimulus(100, 1, 0, 0, 3);
    applyStimulus(100, 1, 1, 0, 3);
    repeat (31) applyStimulus(100, 1, 0, 0, 3);

    $display("[TB] collision on boundary cycle, then reset mid-stun");
    repeat (5) applyStimulus(1000, 1, 0, 0, 3);
    applyStimulus(1000, 1, 0, 1, 3);
    repeat (3) applyStimulus(1000, 1, 0, 0, 3);
    resetDut();

    $display("[TB] run to end of level");
    repeat (3) applyStimulus(1000, 1, 0, 0, 3);
    applyStimulus(600, 1, 0, 0, 3);
    repeat (560) applyStimulus(1000, 1, 0, 0, 3);
    repeat (5) applyStimulus(100, 1, 0, 0, 3);
    applyStimulus(1000, 1, 1, 0, 3);
    repeat (3) applyStimulus(1000, 1, 0, 0, 3);
    applyStimulus(1000, 0, 0, 0, 3);
    applyStimulus(1000, 1, 0, 0, 3);

    $display("[TB] collision on the frame that reaches the end");
    repeat (4) applyStimulus(100, 1, 0, 0, 3);
    guard = 0;
    while (m_mode != M_STUN && guard < 60) begin
      st = (m_dir == 1) ? mSpeed() : 1;
      c  = (m_mode == M_SCROLL) && (m_offset + st >= MAX_OFF);
      applyStimulus(1000, 1, 0, c, 3);
      guard++;
    end
    repeat (3) applyStimulus(1000, 1, 0, 0, 3);

    $display("[TB] random frames");
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 4)      x = $urandom_range(RT + 1, 2047);
      else if (r < 6) x = $urandom_range(0, LT - 1);
      else            x = $urandom_range(0, 2047);
      applyStimulus(x, ($urandom_range(0, 29) != 0),
                    ($urandom_range(0, 11) == 0), ($urandom_range(0, 24) == 0),
                    $urandom_range(3, 6));
    end

    repeat (3) tick;
    checkOutput("queue_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
